// File: rtl/alu_pkg.sv
// Shared opcode constants and state encoding for the ALU arbiter.
package alu_pkg;

    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0110;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } arb_state_e;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin grant: on a tie the requester not served last wins.
module rr_arb2 (
    input  logic valid0,
    input  logic valid1,
    input  logic last_gnt,
    output logic gnt0,
    output logic gnt1,
    output logic gnt_idx
);

    assign gnt0    = valid0 && (!valid1 || last_gnt);
    assign gnt1    = valid1 && (!valid0 || !last_gnt);
    assign gnt_idx = gnt1;

endmodule

// File: rtl/alu_arbiter.sv
// Shares one external ALU between two valid/ready requesters, returning the
// captured result and Zero flag to whichever requester was granted.
//
// state   | meaning
// IDLE    | arbitrate, accept one request, latch ALU pins
// EXEC    | hold ALU pins for ALU_LATENCY+1 cycles, capture on last edge
// RESP    | present result to the granted requester until it consumes it
module alu_arbiter
    import alu_pkg::*;
#(
    parameter int WIDTH       = 32,
    parameter int ALU_LATENCY = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [3:0]       req0_op,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [3:0]       req1_op,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    output logic             rsp0_valid,
    input  logic             rsp0_ready,
    output logic             rsp1_valid,
    input  logic             rsp1_ready,
    output logic [WIDTH-1:0] rsp_result,
    output logic             rsp_zero,
    output logic [3:0]       alu_control,
    output logic [WIDTH-1:0] alu_arg1,
    output logic [WIDTH-1:0] alu_arg2,
    input  logic [WIDTH-1:0] alu_result,
    input  logic             alu_zero,
    output logic             busy
);

    localparam logic [2:0] CNT_LAST = 3'(ALU_LATENCY);

    arb_state_e state, state_nxt;
    logic [2:0] cnt;
    logic       gnt_idx;
    logic       last_gnt;
    logic       arb_gnt0, arb_gnt1, arb_idx;
    logic       accept, exec_done, rsp_fire;

    rr_arb2 u_arb (
        .valid0   (req0_valid),
        .valid1   (req1_valid),
        .last_gnt (last_gnt),
        .gnt0     (arb_gnt0),
        .gnt1     (arb_gnt1),
        .gnt_idx  (arb_idx)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_nxt;
    end

    // ready is gated by rst_n so nothing is offered while reset is held
    always_comb begin
        state_nxt  = state;
        req0_ready = 1'b0;
        req1_ready = 1'b0;
        accept     = 1'b0;
        exec_done  = 1'b0;
        rsp_fire   = 1'b0;
        case (state)
            ST_IDLE: begin
                req0_ready = arb_gnt0 && rst_n;
                req1_ready = arb_gnt1 && rst_n;
                accept     = req0_ready || req1_ready;
                if (accept) state_nxt = ST_EXEC;
            end
            ST_EXEC: begin
                exec_done = (cnt == CNT_LAST);
                if (exec_done) state_nxt = ST_RESP;
            end
            ST_RESP: begin
                rsp_fire = gnt_idx ? rsp1_ready : rsp0_ready;
                if (rsp_fire) state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    assign rsp0_valid = (state == ST_RESP) && !gnt_idx;
    assign rsp1_valid = (state == ST_RESP) &&  gnt_idx;
    assign busy       = (state != ST_IDLE);

    // last_gnt resets to 1 so the first tie goes to req0
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alu_control <= '0;
            alu_arg1    <= '0;
            alu_arg2    <= '0;
            rsp_result  <= '0;
            rsp_zero    <= 1'b0;
            cnt         <= '0;
            gnt_idx     <= 1'b0;
            last_gnt    <= 1'b1;
        end else begin
            if (accept) begin
                alu_control <= arb_idx ? req1_op : req0_op;
                alu_arg1    <= arb_idx ? req1_a  : req0_a;
                alu_arg2    <= arb_idx ? req1_b  : req0_b;
                gnt_idx     <= arb_idx;
                cnt         <= '0;
            end else if ((state == ST_EXEC) && !exec_done) begin
                cnt <= cnt + 3'd1;
            end
            if (exec_done) begin
                rsp_result <= alu_result;
                rsp_zero   <= alu_zero;
            end
            if (rsp_fire) last_gnt <= gnt_idx;
        end
    end

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter: a latency-1 instance plus a latency-0 instance,
// each driven by a small behavioural ALU.
module tb_alu_arbiter;

    localparam logic [3:0] OP_AND = 4'b0000;
    localparam logic [3:0] OP_OR  = 4'b0001;
    localparam logic [3:0] OP_ADD = 4'b0010;
    localparam logic [3:0] OP_SUB = 4'b0110;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req0_valid = 0, req1_valid = 0;
    logic        req0_ready, req1_ready;
    logic [3:0]  req0_op = '0, req1_op = '0;
    logic [31:0] req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
    logic        rsp0_valid, rsp1_valid;
    logic        rsp0_ready = 0, rsp1_ready = 0;
    logic [31:0] rsp_result;
    logic        rsp_zero;
    logic [3:0]  alu_control;
    logic [31:0] alu_arg1, alu_arg2, alu_result;
    logic        alu_zero, busy;
    logic [31:0] alu_q = '0;

    logic        z_req0_valid = 0;
    logic        z_req0_ready, z_req1_ready;
    logic [3:0]  z_req0_op = '0;
    logic [31:0] z_req0_a = '0, z_req0_b = '0;
    logic        z_rsp0_valid, z_rsp1_valid;
    logic        z_rsp0_ready = 0;
    logic [31:0] z_rsp_result;
    logic        z_rsp_zero;
    logic [3:0]  z_alu_control;
    logic [31:0] z_alu_arg1, z_alu_arg2, z_alu_result;
    logic        z_alu_zero, z_busy;

    int n_checks = 0;
    int n_err    = 0;

    always #5 clk = ~clk;

    function automatic logic [31:0] alu_fn(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        case (op)
            OP_AND:  return a & b;
            OP_OR:   return a | b;
            OP_ADD:  return a + b;
            OP_SUB:  return a - b;
            default: return '0;
        endcase
    endfunction

    // one-edge ALU for the latency-1 instance, combinational ALU for latency-0
    always_ff @(posedge clk) alu_q <= alu_fn(alu_control, alu_arg1, alu_arg2);
    assign alu_result   = alu_q;
    assign alu_zero     = (alu_q == '0);
    assign z_alu_result = alu_fn(z_alu_control, z_alu_arg1, z_alu_arg2);
    assign z_alu_zero   = (z_alu_result == '0);

    alu_arbiter #(.WIDTH(32), .ALU_LATENCY(1)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op), .req0_a(req0_a), .req0_b(req0_b),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op), .req1_a(req1_a), .req1_b(req1_b),
        .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready), .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready),
        .rsp_result(rsp_result), .rsp_zero(rsp_zero),
        .alu_control(alu_control), .alu_arg1(alu_arg1), .alu_arg2(alu_arg2),
        .alu_result(alu_result), .alu_zero(alu_zero), .busy(busy)
    );

    alu_arbiter #(.WIDTH(32), .ALU_LATENCY(0)) dut_lat0 (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(z_req0_valid), .req0_ready(z_req0_ready), .req0_op(z_req0_op), .req0_a(z_req0_a), .req0_b(z_req0_b),
        .req1_valid(1'b0), .req1_ready(z_req1_ready), .req1_op(4'b0000), .req1_a(32'd0), .req1_b(32'd0),
        .rsp0_valid(z_rsp0_valid), .rsp0_ready(z_rsp0_ready), .rsp1_valid(z_rsp1_valid), .rsp1_ready(1'b0),
        .rsp_result(z_rsp_result), .rsp_zero(z_rsp_zero),
        .alu_control(z_alu_control), .alu_arg1(z_alu_arg1), .alu_arg2(z_alu_arg2),
        .alu_result(z_alu_result), .alu_zero(z_alu_zero), .busy(z_busy)
    );

    task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_all_zero(input string tag);
        check_val({tag, " req0_ready"}, req0_ready, 0);
        check_val({tag, " req1_ready"}, req1_ready, 0);
        check_val({tag, " rsp0_valid"}, rsp0_valid, 0);
        check_val({tag, " rsp1_valid"}, rsp1_valid, 0);
        check_val({tag, " rsp_result"}, rsp_result, 0);
        check_val({tag, " rsp_zero"}, rsp_zero, 0);
        check_val({tag, " alu_control"}, alu_control, 0);
        check_val({tag, " alu_arg1"}, alu_arg1, 0);
        check_val({tag, " alu_arg2"}, alu_arg2, 0);
        check_val({tag, " busy"}, busy, 0);
    endtask

    // single request on one port, no competitor; response expected in cycle 3
    task automatic run_op(input string tag, input bit idx, input logic [3:0] op,
                          input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp_r, input logic exp_z);
        if (!idx) begin req0_valid = 1; req0_op = op; req0_a = a; req0_b = b; end
        else      begin req1_valid = 1; req1_op = op; req1_a = a; req1_b = b; end
        #1;
        check_val({tag, " c0 ready"}, idx ? req1_ready : req0_ready, 1);
        check_val({tag, " c0 other ready"}, idx ? req0_ready : req1_ready, 0);
        tick();
        req0_valid = 0; req1_valid = 0;
        check_val({tag, " c1 busy"}, busy, 1);
        check_val({tag, " c1 alu_control"}, alu_control, op);
        check_val({tag, " c1 alu_arg1"}, alu_arg1, a);
        check_val({tag, " c1 alu_arg2"}, alu_arg2, b);
        tick();
        check_val({tag, " c2 alu_control"}, alu_control, op);
        check_val({tag, " c2 rsp_valid"}, idx ? rsp1_valid : rsp0_valid, 0);
        tick();
        check_val({tag, " c3 rsp_valid"}, idx ? rsp1_valid : rsp0_valid, 1);
        check_val({tag, " c3 other rsp_valid"}, idx ? rsp0_valid : rsp1_valid, 0);
        check_val({tag, " c3 rsp_result"}, rsp_result, exp_r);
        check_val({tag, " c3 rsp_zero"}, rsp_zero, exp_z);
        if (!idx) rsp0_ready = 1; else rsp1_ready = 1;
        tick();
        rsp0_ready = 0; rsp1_ready = 0;
        check_val({tag, " done busy"}, busy, 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        // reset, with a request already pending so gated ready is observed
        req0_valid = 1;
        tick(); tick();
        check_all_zero("reset");
        req0_valid = 0;
        rst_n = 1;
        tick();

        // concurrent: first tie goes to req0, req1 follows after the handshake
        req0_valid = 1; req0_op = OP_OR;  req0_a = 32'h4e0f92be; req0_b = 32'h080011f3;
        req1_valid = 1; req1_op = OP_ADD; req1_a = 32'h1234fedc; req1_b = 32'h00742069;
        #1;
        check_val("tie1 req0_ready", req0_ready, 1);
        check_val("tie1 req1_ready", req1_ready, 0);
        tick();
        req0_valid = 0;
        check_val("tie1 c1 req1_ready", req1_ready, 0);
        check_val("tie1 c1 alu_control", alu_control, OP_OR);
        tick();
        check_val("tie1 c2 req1_ready", req1_ready, 0);
        tick();
        check_val("tie1 rsp0_valid", rsp0_valid, 1);
        check_val("tie1 rsp1_valid", rsp1_valid, 0);
        check_val("tie1 rsp_result", rsp_result, 32'h4e0f93ff);
        rsp0_ready = 1;
        tick();
        rsp0_ready = 0;
        check_val("tie1 next req1_ready", req1_ready, 1);
        tick();
        req1_valid = 0;
        check_val("tie1 req1 alu_control", alu_control, OP_ADD);
        tick(); tick();
        check_val("tie1 rsp1_valid", rsp1_valid, 1);
        check_val("tie1 rsp0_valid late", rsp0_valid, 0);
        check_val("tie1 rsp1 result", rsp_result, 32'h12a91f45);
        check_val("tie1 rsp1 zero", rsp_zero, 0);
        rsp1_ready = 1;
        tick();
        rsp1_ready = 0;
        req0_valid = 1; req1_valid = 1;
        #1;
        check_val("tie2 req0_ready", req0_ready, 1);
        check_val("tie2 req1_ready", req1_ready, 0);
        req0_valid = 0; req1_valid = 0;
        tick();
        check_val("tie2 no accept", busy, 0);

        run_op("and", 1'b0, OP_AND, 32'h4e0f92be, 32'h080011f3, 32'h080010b2, 1'b0);
        run_op("sub_zero", 1'b1, OP_SUB, 32'h11110000, 32'h11110000, 32'h00000000, 1'b1);

        // backpressure on rsp0 while req1 waits
        req0_valid = 1; req0_op = OP_ADD; req0_a = 32'd1; req0_b = 32'd2;
        tick();
        req0_valid = 0;
        req1_valid = 1; req1_op = OP_AND; req1_a = 32'hffff0000; req1_b = 32'h0f0f0f0f;
        tick(); tick();
        for (int i = 0; i < 10; i++) begin
            check_val("bp rsp0_valid", rsp0_valid, 1);
            check_val("bp rsp_result", rsp_result, 32'd3);
            check_val("bp req1_ready", req1_ready, 0);
            check_val("bp busy", busy, 1);
            tick();
        end
        rsp0_ready = 1;
        #1;
        check_val("bp hs req1_ready", req1_ready, 0);
        tick();
        rsp0_ready = 0;
        check_val("bp after req1_ready", req1_ready, 1);
        tick();
        req1_valid = 0;
        tick(); tick();
        check_val("bp rsp1_valid", rsp1_valid, 1);
        check_val("bp rsp1 result", rsp_result, 32'h0f0f0000);
        rsp1_ready = 1;
        tick();
        rsp1_ready = 0;

        // reset in cycle 1 of an op
        req0_valid = 1; req0_op = OP_ADD; req0_a = 32'd5; req0_b = 32'd6;
        tick();
        req0_valid = 0;
        check_val("rst pre busy", busy, 1);
        rst_n = 0;
        #1;
        check_all_zero("rst mid");
        tick();
        rst_n = 1;
        for (int i = 0; i < 5; i++) begin
            tick();
            check_val("rst post rsp0_valid", rsp0_valid, 0);
            check_val("rst post busy", busy, 0);
        end
        run_op("post_rst", 1'b0, OP_SUB, 32'd10, 32'd3, 32'd7, 1'b0);

        // latency-0 instance: response in cycle 2
        z_req0_valid = 1; z_req0_op = OP_AND; z_req0_a = 32'h00000001; z_req0_b = 32'h00000000;
        #1;
        check_val("lat0 c0 ready", z_req0_ready, 1);
        tick();
        z_req0_valid = 0;
        check_val("lat0 c1 busy", z_busy, 1);
        check_val("lat0 c1 rsp0_valid", z_rsp0_valid, 0);
        tick();
        check_val("lat0 c2 rsp0_valid", z_rsp0_valid, 1);
        check_val("lat0 c2 rsp1_valid", z_rsp1_valid, 0);
        check_val("lat0 rsp_result", z_rsp_result, 32'h0);
        check_val("lat0 rsp_zero", z_rsp_zero, 1);
        z_rsp0_ready = 1;
        tick();
        z_rsp0_ready = 0;
        check_val("lat0 done busy", z_busy, 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
